// File: rtl/mem_bus_master_pkg.sv
// Shared definitions for the CVP14 memory-bus initiator.
// Holds the FSM state encoding and the default halt address.
package mem_bus_master_pkg;

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StDrain     = 2'd1,
        StHaltIssue = 2'd2,
        StHalted    = 2'd3
    } state_e;

    localparam logic [15:0] HaltAddrDefault = 16'hFFFF;

endpackage

// File: rtl/mem_bus_req_fifo.sv
// Synchronous request FIFO for the memory-bus initiator.
// Ports:
//   clk    in          sole clock, posedge
//   reset  in          synchronous, active-high; flushes the FIFO
//   push   in          write wdata (ignored when full)
//   pop    in          drop head entry (ignored when empty)
//   wdata  in  WIDTH   entry to write
//   rdata  out WIDTH   head entry (valid when !empty)
//   full   out         DEPTH entries held
//   empty  out         no entries held
module mem_bus_req_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PtrOne = 1;
    localparam logic [PTR_W:0] CntOne = 1;
    localparam logic [PTR_W:0] CntFull = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    // One extra count bit separates full from empty.
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CntFull);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntOne;
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/mem_bus_master.sv
// CPU-side initiator for the CVP14 memory bus. Buffers core load/store requests, issues at
// most one bus access per cycle, returns read data in issue order, and on halt drives
// Addr = HALT_ADDR for one cycle before going quiet.
// Ports:
//   Clk1, Reset                  clock / synchronous active-high reset
//   req_valid/ready/we/addr/wdata core request handshake
//   rsp_valid, rsp_rdata         one-cycle read-data pulse
//   halt_req, halted, busy       end-of-run control and status
//   Addr, RD, WR, DataOut, DataIn memory bus
// Optional feature: define MEM_BUS_TRACE_EN for a simulation-only bus trace and RD&WR check.
module mem_bus_master
    import mem_bus_master_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       REQ_DEPTH = 2,
    parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(HaltAddrDefault)
) (
    input  logic              Clk1,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              halt_req,
    output logic              halted,
    output logic              busy,
    output logic [ADDR_W-1:0] Addr,
    output logic              RD,
    output logic              WR,
    output logic [DATA_W-1:0] DataOut,
    input  logic [DATA_W-1:0] DataIn
);
    localparam int unsigned EntryW = 1 + ADDR_W + DATA_W;

    state_e            state_q, state_d;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [EntryW-1:0] fifo_wdata, fifo_rdata;
    logic              head_we;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              issue_en;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dout_q;
    logic              rd_q, wr_q;
    // Bit 0: read issued last edge; bit 1: memory has DataIn ready for capture.
    logic [1:0]        rd_inflight_q;

    assign fifo_wdata                     = {req_we, req_addr, req_wdata};
    assign {head_we, head_addr, head_data} = fifo_rdata;
    assign fifo_push                      = req_valid && req_ready;
    assign fifo_pop                       = issue_en && !fifo_empty;

    mem_bus_req_fifo #(
        .DEPTH (REQ_DEPTH),
        .WIDTH (EntryW)
    ) u_req_fifo (
        .clk   (Clk1),
        .reset (Reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FSM: state register
    always_ff @(posedge Clk1) begin
        if (Reset) state_q <= StRun;
        else       state_q <= state_d;
    end

    // FSM: next state. A halt_req dropped during drain does not cancel the halt.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:       if (halt_req) state_d = StDrain;
            StDrain:     if (fifo_empty && (rd_inflight_q == 2'b00)) state_d = StHaltIssue;
            StHaltIssue: state_d = StHalted;
            StHalted:    state_d = StHalted;
            default:     state_d = StRun;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready = 1'b0;
        issue_en  = 1'b0;
        halted    = 1'b0;
        Addr      = addr_q;
        unique case (state_q)
            StRun: begin
                req_ready = !fifo_full;
                issue_en  = 1'b1;
            end
            StDrain:     issue_en = 1'b1;
            StHaltIssue: Addr     = HALT_ADDR;
            StHalted:    halted   = 1'b1;
            default:     ;
        endcase
    end

    // Bus strobes last one cycle; Addr/DataOut only change on an issue.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            addr_q        <= '0;
            dout_q        <= '0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            rd_inflight_q <= 2'b00;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
        end else begin
            rd_q          <= fifo_pop && !head_we;
            wr_q          <= fifo_pop && head_we;
            rd_inflight_q <= {rd_inflight_q[0], fifo_pop && !head_we};
            rsp_valid     <= rd_inflight_q[1];
            if (fifo_pop) begin
                addr_q <= head_addr;
                dout_q <= head_data;
            end
            if (rd_inflight_q[1]) rsp_rdata <= DataIn;
        end
    end

    assign RD      = rd_q;
    assign WR      = wr_q;
    assign DataOut = dout_q;
    assign busy    = !fifo_empty || (rd_inflight_q != 2'b00);

`ifdef MEM_BUS_TRACE_EN
    always @(posedge Clk1) begin
        if (!Reset) begin
            if (RD)        $display("RD %h ----", Addr);
            if (WR)        $display("WR %h %h", Addr, DataOut);
            if (rsp_valid) $display("RSP %h", rsp_rdata);
            if (RD && WR)  $error("RD and WR both asserted, Addr=%h", Addr);
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master with a behavioural memory (testmem stand-in) that
// acts on the Clk1 edge after a strobe, plus a direct check of the request FIFO.
module tb_mem_bus_master;

    localparam logic [15:0] HaltA = 16'hFFFF;

    logic        Clk1, Reset;
    logic        req_valid, req_ready, req_we;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        halt_req, halted, busy;
    logic [15:0] Addr, DataOut, DataIn;
    logic        RD, WR;

    logic        f_reset, f_push, f_pop, f_full, f_empty;
    logic [7:0]  f_wdata, f_rdata;

    int          checks, passed;
    int          rsp_count, dump_cnt;
    logic [15:0] mem     [65536];
    logic [15:0] ref_mem [65536];
    logic [15:0] exp_q   [$];

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;
    vec_t vecs [6];

    mem_bus_master dut (
        .Clk1      (Clk1),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .halt_req  (halt_req),
        .halted    (halted),
        .busy      (busy),
        .Addr      (Addr),
        .RD        (RD),
        .WR        (WR),
        .DataOut   (DataOut),
        .DataIn    (DataIn)
    );

    mem_bus_req_fifo #(
        .DEPTH (2),
        .WIDTH (8)
    ) u_fifo (
        .clk   (Clk1),
        .reset (f_reset),
        .push  (f_push),
        .pop   (f_pop),
        .wdata (f_wdata),
        .rdata (f_rdata),
        .full  (f_full),
        .empty (f_empty)
    );

    initial begin
        Clk1 = 1'b0;
        forever #5 Clk1 = ~Clk1;
    end

    function automatic logic [15:0] init_val(input int unsigned a);
        if (a == 32'h10) return 16'hBEEF;
        return 16'(a * 37 + 257);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge Clk1);
        #1;
    endtask

    // Memory: acts on the edge after the strobe; read data valid until the next access.
    always @(posedge Clk1) begin
        if (RD) DataIn <= mem[Addr];
        if (WR) mem[Addr] <= DataOut;
    end

    // Reference model: in-order bus, so every accepted read returns the memory
    // contents as left by all earlier accepted writes.
    always @(negedge Clk1) begin
        chk("rd_wr_excl", {31'b0, RD & WR}, 0);
        if (rsp_valid) begin
            rsp_count++;
            if (exp_q.size() == 0) chk("rsp_unexpected", {31'b0, rsp_valid}, 0);
            else chk("rsp_data", {16'b0, rsp_rdata}, {16'b0, exp_q.pop_front()});
        end
        if (Addr == HaltA && !RD && !WR) dump_cnt++;
        if (Reset) exp_q.delete();
        else if (req_valid && req_ready) begin
            if (req_we) ref_mem[req_addr] = req_wdata;
            else        exp_q.push_back(ref_mem[req_addr]);
        end
    end

    task automatic run_vec(input vec_t v);
        chk("vec_ready", {31'b0, req_ready}, 1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        step();  // accept
        req_valid = 1'b0;
        chk("vec_no_bypass", {30'b0, RD, WR}, 0);
        step();  // issue
        chk("vec_issue_rd", {31'b0, RD}, {31'b0, !v.we});
        chk("vec_issue_wr", {31'b0, WR}, {31'b0, v.we});
        chk("vec_issue_addr", {16'b0, Addr}, {16'b0, v.addr});
        if (v.we) chk("vec_dataout", {16'b0, DataOut}, {16'b0, v.wdata});
        step();
        chk("vec_strobe_1cyc", {30'b0, RD, WR}, 0);
        chk("vec_rsp_early", {31'b0, rsp_valid}, 0);
        step();  // three cycles after accept
        chk("vec_rsp_valid", {31'b0, rsp_valid}, {31'b0, !v.we});
        if (!v.we) chk("vec_rsp_rdata", {16'b0, rsp_rdata}, {16'b0, v.exp_rdata});
        step();
        chk("vec_rsp_pulse", {31'b0, rsp_valid}, 0);
    endtask

    initial begin
        int r0, d0, c;
        checks = 0; passed = 0; rsp_count = 0; dump_cnt = 0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     <= init_val(i);
            ref_mem[i]  = init_val(i);
        end
        DataIn <= '0;
        vecs[0] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[1] = '{1'b1, 16'h0020, 16'h1234, 16'h0000};
        vecs[2] = '{1'b0, 16'h0020, 16'h0000, 16'h1234};
        vecs[3] = '{1'b0, 16'hFFFF, 16'h0000, init_val(32'hFFFF)};
        vecs[4] = '{1'b1, 16'h0030, 16'hA5A5, 16'h0000};
        vecs[5] = '{1'b0, 16'h0030, 16'h0000, 16'hA5A5};

        Reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        halt_req = 1'b0; f_reset = 1'b1; f_push = 1'b0; f_pop = 1'b0; f_wdata = '0;
        step(); step();
        chk("rst_addr", {16'b0, Addr}, 0);
        chk("rst_strobes", {30'b0, RD, WR}, 0);
        chk("rst_dataout", {16'b0, DataOut}, 0);
        chk("rst_rsp", {15'b0, rsp_valid, rsp_rdata}, 0);
        chk("rst_halted", {31'b0, halted}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_ready", {31'b0, req_ready}, 1);
        Reset = 1'b0;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Four back-to-back reads: one issue per cycle, ready never drops.
        req_valid = 1'b1; req_we = 1'b0; r0 = rsp_count;
        for (int i = 0; i < 4; i++) begin
            req_addr = 16'(i);
            chk("b2b_ready", {31'b0, req_ready}, 1);
            step();
            if (i > 0) begin
                chk("b2b_rd", {31'b0, RD}, 1);
                chk("b2b_addr", {16'b0, Addr}, i - 1);
            end
        end
        req_valid = 1'b0;
        step();
        chk("b2b_rd_last", {31'b0, RD}, 1);
        chk("b2b_addr_last", {16'b0, Addr}, 3);
        repeat (4) step();
        chk("b2b_rsp_count", rsp_count - r0, 4);

        // Random mix of reads and writes against the reference model.
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = $urandom_range(0, 1) == 1;
            req_addr  = 16'($urandom_range(0, 15));
            req_wdata = 16'($urandom);
            step();
        end
        req_valid = 1'b0;
        c = 0;
        while ((busy || exp_q.size() != 0) && c < 20) begin
            step();
            c++;
        end
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_idle", {31'b0, busy}, 0);

        // Reset the cycle after a read issue: the read is dropped.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
        step();
        req_valid = 1'b0;
        step();
        chk("mid_rd_issued", {31'b0, RD}, 1);
        Reset = 1'b1;
        step();
        chk("mid_rst_strobes", {30'b0, RD, WR}, 0);
        chk("mid_rst_addr", {16'b0, Addr}, 0);
        chk("mid_rst_rsp", {31'b0, rsp_valid}, 0);
        chk("mid_rst_ready", {31'b0, req_ready}, 1);
        Reset = 1'b0; r0 = rsp_count;
        repeat (5) step();
        chk("mid_rst_no_rsp", rsp_count - r0, 0);

        // Halt with two reads queued; halt_req dropped during drain.
        r0 = rsp_count; d0 = dump_cnt;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
        step();
        req_addr = 16'h0011; halt_req = 1'b1;
        step();
        req_valid = 1'b0; halt_req = 1'b0;
        chk("drain_ready", {31'b0, req_ready}, 0);
        c = 0;
        while (!halted && c < 20) begin
            if (Addr == HaltA) chk("halt_after_rsps", rsp_count - r0, 2);
            step();
            c++;
        end
        chk("halted", {31'b0, halted}, 1);
        chk("halt_addr_once", dump_cnt - d0, 1);
        repeat (3) step();
        chk("halted_sticky", {31'b0, halted}, 1);
        chk("halted_quiet", {30'b0, RD, WR}, 0);
        chk("halted_ready", {31'b0, req_ready}, 0);
        chk("halt_rsp_total", rsp_count - r0, 2);

        // FIFO: push while full with a simultaneous pop.
        f_reset = 1'b0;
        chk("fifo_empty0", {30'b0, f_empty, f_full}, 2);
        f_push = 1'b1; f_wdata = 8'hA1;
        step();
        f_wdata = 8'hB2;
        step();
        chk("fifo_full", {30'b0, f_empty, f_full}, 1);
        chk("fifo_head_a", {24'b0, f_rdata}, 32'hA1);
        f_wdata = 8'hC3; f_pop = 1'b1;
        step();
        f_push = 1'b0;
        chk("fifo_after_pp", {30'b0, f_empty, f_full}, 0);
        chk("fifo_head_b", {24'b0, f_rdata}, 32'hB2);
        step();
        f_pop = 1'b0;
        chk("fifo_no_push", {30'b0, f_empty, f_full}, 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
